// File: rtl/neuron_pkg.sv
// Shared types and helpers for the dense-layer neuron scheduler.
// Holds the FSM state encoding, default data width and activation predicate.
package neuron_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        MAC,
        OUT
    } state_e;

    // True when the activation must force the result to zero (negative under ReLU).
    function automatic logic relu_clamp(input logic en, input logic sign);
        return en & sign;
    endfunction

endpackage

// File: rtl/neuron_post_act.sv
// Post-MAC stage: bias add (wrapping) followed by optional ReLU.
// Kept combinational so a pipelined MAC can later slot in ahead of it.
module neuron_post_act
    import neuron_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter bit RELU_EN = 1'b1
) (
    input  logic [DW-1:0] mac_result_i,
    input  logic [DW-1:0] bias_i,
    output logic [DW-1:0] result_o
);

    logic [DW-1:0] sum;

    assign sum      = mac_result_i + bias_i;
    assign result_o = relu_clamp(RELU_EN, sum[DW-1]) ? '0 : sum;

endmodule

// File: rtl/neuron_layer_sched.sv
// Time-multiplexes one external combinational MAC over the M neurons of a
// dense layer: latch vector, then per neuron fetch row/bias, MAC, stream out.
module neuron_layer_sched
    import neuron_pkg::*;
#(
    parameter int N       = 4,
    parameter int M       = 8,
    parameter int DW      = DW_DEF,
    parameter bit RELU_EN = 1'b1,
    parameter int AW      = (M > 1) ? $clog2(M) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] in_data,
    output logic            mem_rd_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW*N-1:0] mem_w_data,
    input  logic [DW-1:0]   mem_b_data,
    output logic [DW*N-1:0] mac_inputs,
    output logic [DW*N-1:0] mac_weights,
    input  logic [DW-1:0]   mac_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [AW-1:0]   out_idx,
    output logic            out_last,
    output logic            busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   j_q, j_d;
    logic [DW*N-1:0] x_q, x_d;
    logic [DW*N-1:0] w_q, w_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   od_q, od_d;
    logic [AW-1:0]   oidx_q, oidx_d;
    logic            olast_q, olast_d;
    logic [DW-1:0]   act;

    neuron_post_act #(
        .DW      (DW),
        .RELU_EN (RELU_EN)
    ) u_post_act (
        .mac_result_i (mac_result),
        .bias_i       (b_q),
        .result_o     (act)
    );

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        od_d    = od_q;
        oidx_d  = oidx_q;
        olast_d = olast_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    j_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                // Memory has one cycle of read latency: data is on the bus now.
                w_d     = mem_w_data;
                b_d     = mem_b_data;
                state_d = MAC;
            end
            MAC: begin
                od_d    = act;
                oidx_d  = j_q;
                olast_d = (j_q == LAST_IDX);
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (j_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        j_d     = j_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
            od_q    <= '0;
            oidx_q  <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            x_q     <= x_d;
            w_q     <= w_d;
            b_q     <= b_d;
            od_q    <= od_d;
            oidx_q  <= oidx_d;
            olast_q <= olast_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mem_rd_en   = (state_q == FETCH);
    assign mem_addr    = j_q;
    assign mac_inputs  = x_q;
    assign mac_weights = w_q;
    assign out_valid   = (state_q == OUT);
    assign out_data    = od_q;
    assign out_idx     = oidx_q;
    assign out_last    = olast_q;

endmodule

// File: doc/neuron_layer_sched.md
Name: neuron_layer_sched

Overview:
- Sequencer that time-multiplexes one combinational `neuron` MAC instance (N inputs, 16-bit) over the M output neurons of a dense layer.
- Latches one input vector, then for each output neuron j:
  - fetches weight row j and bias j from an external synchronous ROM/RAM;
  - drives the MAC and adds the bias;
  - optionally applies ReLU;
  - streams the result out over a valid/ready handshake.
- Sits between the layer input FIFO and the next layer / result buffer.

Parameters:
- N, 4, inputs per neuron (MAC fan-in); must match the attached neuron instance.
- M, 8, output neurons per layer; M >= 1.
- DW, 16, data width of every input, weight, bias and result element.
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass-through.
- AW, $clog2(M) (min 1), width of the weight/bias address and of out_idx.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector (high only in IDLE)
- in_data  in  DW*N  input vector; element i at [DW*(i+1)-1 -: DW]
- mem_rd_en  out  1  read strobe to weight/bias memory
- mem_addr  out  AW  neuron index j being fetched
- mem_w_data  in  DW*N  weight row j; valid the cycle after mem_rd_en (1-cycle read latency)
- mem_b_data  in  DW  bias j; same timing as mem_w_data
- mac_inputs  out  DW*N  to neuron.inputs; the latched input vector
- mac_weights  out  DW*N  to neuron.weights; the latched weight row
- mac_result  in  DW  from neuron.result; combinational function of mac_inputs/mac_weights
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  post-bias, post-activation result for neuron out_idx
- out_idx  out  AW  index j of the current result
- out_last  out  1  high with out_valid when out_idx == M-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert at the next clk edge): state = IDLE, j = 0, all outputs and internal registers = 0. Reset mid-layer aborts the layer; no partial results are emitted afterwards.
- FSM states: IDLE, FETCH, WAIT, MAC, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data into x_reg, set j = 0, go to FETCH.
- FETCH: mem_rd_en = 1, mem_addr = j; go to WAIT. mem_rd_en is 0 in every other state.
- WAIT: register mem_w_data into w_reg and mem_b_data into b_reg; go to MAC.
- MAC:
  - mac_inputs = x_reg and mac_weights = w_reg (both held constant from the load until the next load).
  - sum = mac_result + b_reg, modulo 2^DW, interpreted as two's complement.
  - If RELU_EN and sum[DW-1] = 1, out_data = 0; otherwise out_data = sum. Register out_data, out_idx = j, out_last = (j == M-1).
  - Go to OUT.
- OUT:
  - out_valid = 1; out_data, out_idx and out_last are held stable until the handshake.
  - On out_ready: if j == M-1, go to IDLE; else j = j+1 and go to FETCH.
  - out_ready low stalls indefinitely with no state change.
- Latency:
  - First out_valid is high 3 clock edges after the input handshake edge.
  - Each neuron takes at least 4 cycles (FETCH, WAIT, MAC, OUT).
  - A full layer with out_ready tied high takes 4*M cycles, plus 1 cycle to accept the next vector.
- in_valid while busy is ignored (in_ready = 0); in_data may change freely while busy.
- The last-result handshake and a new in_valid in the same cycle: the new vector is accepted no earlier than the following cycle, when the block is in IDLE.
- M = 1: out_last is high on the first and only result.
- mac_result overflow is the MAC's own wrap; the scheduler adds no saturation.

Decomposition:
- Package neuron_pkg:
  - state enum (IDLE, FETCH, WAIT, MAC, OUT);
  - DW default constant;
  - the relu_clamp function.
- Sub-module neuron_post_act: combinational bias add plus optional ReLU (params DW, RELU_EN). The neuron MAC stays external, so the same scheduler can drive a pipelined MAC later.

Test Plan:
- Inputs 1,2,3,4; every weight row all ones; bias j = j; N=4, M=8; out_ready = 1 -> out_data 10..17, out_idx 0..7, out_last only on idx 7, 32 cycles total.
- Inputs 5,6,7,8; weights all 2; bias 0 -> every result is 52; out_valid first high 3 edges after accept.
- Weights row 0 = -1 (0xFFFF) ×4 with inputs 1,2,3,4; bias 0 -> RELU_EN=1 gives 0x0000, RELU_EN=0 gives 0xFFF6.
- out_ready held low 5 cycles on idx 2 -> out_data/out_idx stable, mem_rd_en stays 0, busy = 1; the sequence resumes with idx 3.
- rst_n pulsed low during WAIT of idx 4 -> all outputs 0 immediately, in_ready = 1 after deassert; a new vector restarts at idx 0.
- in_valid held high across the whole layer -> second vector accepted exactly one cycle after the out_last handshake.
